// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: 4-digit common-anode seven-segment scan controller.
// Double-buffered display data, committed only at frame boundaries.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   load            one-cycle strobe capturing hex_in / dp_in / blank_lz
//   hex_in[15:0]    four hex digits, [3:0] is digit 0 (rightmost)
//   dp_in[3:0]      decimal-point enables, active-high, bit k -> digit k
//   blank_lz        leading-zero blanking enable
//   an[3:0]         anode enables, active-low, bit k -> digit k
//   sseg[7:0]       segments, active-low, [7]=dp, [6:0]={a,b,c,d,e,f,g}
//   pending         loaded value waiting for the next frame boundary
//   frame_done      one-cycle pulse after each frame wrap
module sseg_scan_ctrl #(
    parameter int N = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] hex_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [7:0]  sseg,
    output logic        pending,
    output logic        frame_done
);

    logic [N-1:0] q;
    logic [1:0]   idx;
    logic         tick;
    logic         wrap;

    logic [15:0]  sh_hex;
    logic [3:0]   sh_dp;
    logic         sh_lz;

    logic [15:0]  a_hex;
    logic [3:0]   a_dp;
    logic         a_lz;

    logic [3:0]   nib;
    logic         dp_n;
    logic [6:0]   seg;
    logic         z3, z2, z1;
    logic         blank;
    logic [3:0]   an_d;
    logic [7:0]   sseg_d;

    assign tick = (q == {N{1'b1}});
    assign wrap = tick && (idx == 2'd3);

    // Scan counters, shadow/active buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            q          <= '0;
            idx        <= 2'd0;
            sh_hex     <= 16'h0000;
            sh_dp      <= 4'h0;
            sh_lz      <= 1'b0;
            a_hex      <= 16'h0000;
            a_dp       <= 4'h0;
            a_lz       <= 1'b0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= 4'b1111;
            sseg       <= 8'hFF;
        end else begin
            q <= q + {{(N-1){1'b0}}, 1'b1};
            if (tick) begin
                idx <= idx + 2'd1;
            end

            if (load) begin
                sh_hex <= hex_in;
                sh_dp  <= dp_in;
                sh_lz  <= blank_lz;
            end

            // A load landing on the wrap bypasses the shadow so it
            // is shown in the very next frame without a pending phase.
            if (wrap) begin
                pending <= 1'b0;
                if (load) begin
                    a_hex <= hex_in;
                    a_dp  <= dp_in;
                    a_lz  <= blank_lz;
                end else if (pending) begin
                    a_hex <= sh_hex;
                    a_dp  <= sh_dp;
                    a_lz  <= sh_lz;
                end
            end else if (load) begin
                pending <= 1'b1;
            end

            frame_done <= wrap;
            an         <= an_d;
            sseg       <= sseg_d;
        end
    end

    // Digit select for the current slot.
    always_comb begin
        nib  = a_hex[3:0];
        dp_n = ~a_dp[0];
        unique case (idx)
            2'd0: begin nib = a_hex[3:0];   dp_n = ~a_dp[0]; end
            2'd1: begin nib = a_hex[7:4];   dp_n = ~a_dp[1]; end
            2'd2: begin nib = a_hex[11:8];  dp_n = ~a_dp[2]; end
            2'd3: begin nib = a_hex[15:12]; dp_n = ~a_dp[3]; end
        endcase
    end

    // Hex to segment decoder, active-low {a,b,c,d,e,f,g}.
    always_comb begin
        seg = 7'b1111111;
        unique case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
    end

    // zK: every nibble from digit K up to digit 3 is zero.
    assign z3 = ~|a_hex[15:12];
    assign z2 = z3 & ~|a_hex[11:8];
    assign z1 = z2 & ~|a_hex[7:4];

    always_comb begin
        blank = 1'b0;
        if (a_lz) begin
            unique case (idx)
                2'd0: blank = 1'b0;
                2'd1: blank = z1;
                2'd2: blank = z2;
                2'd3: blank = z3;
            endcase
        end
    end

    always_comb begin
        an_d   = 4'b1111;
        sseg_d = 8'hFF;
        if (!blank) begin
            an_d   = ~(4'b0001 << idx);
            sseg_d = {dp_n, seg};
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: directed scoreboard bench for sseg_scan_ctrl, N=2.
// Each slot's expected an/sseg/pending/frame_done is queued, then checked.
module tb_sseg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        pending;
    logic        frame_done;

    sseg_scan_ctrl #(.N(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .sseg       (sseg),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [7:0] sseg;
        logic       pend;
        logic       fd;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [15:0] disp_hex = 16'h0000;
    logic [3:0]  disp_dp  = 4'h0;
    logic        disp_lz  = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    function automatic exp_t expect_slot(
        input string       tag,
        input logic [15:0] hx,
        input logic [3:0]  dp,
        input logic        lz,
        input int          i,
        input logic        pend,
        input logic        fd
    );
        exp_t e;
        int   s;
        logic blank;
        s = i / 4;
        blank = lz && (s != 0);
        for (int k = s; k < 4; k++) begin
            if (hx[4*k +: 4] != 4'h0) blank = 1'b0;
        end
        e.tag  = tag;
        e.pend = pend;
        e.fd   = fd;
        if (blank) begin
            e.an   = 4'b1111;
            e.sseg = 8'hFF;
        end else begin
            e.an    = 4'b1111;
            e.an[s] = 1'b0;
            e.sseg  = {~dp[s], seg_of(hx[4*s +: 4])};
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        assert (an === e.an) else begin
            n_bad++;
            $error("FAIL %s an observed=%b expected=%b", e.tag, an, e.an);
        end
        n_cmp++;
        assert (sseg === e.sseg) else begin
            n_bad++;
            $error("FAIL %s sseg observed=%h expected=%h",
                   e.tag, sseg, e.sseg);
        end
        n_cmp++;
        assert (pending === e.pend) else begin
            n_bad++;
            $error("FAIL %s pending observed=%b expected=%b",
                   e.tag, pending, e.pend);
        end
        n_cmp++;
        assert (frame_done === e.fd) else begin
            n_bad++;
            $error("FAIL %s frame_done observed=%b expected=%b",
                   e.tag, frame_done, e.fd);
        end
    endtask

    // One 16-slot output frame; loads at slot la1/la2, reset at rst_at.
    task automatic run_frame(
        input string       tag,
        input int          la1,
        input logic [15:0] h1,
        input int          la2,
        input logic [15:0] h2,
        input logic [3:0]  dp,
        input logic        lz,
        input int          rst_at
    );
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            logic p;
            p = (i <= 14) && ((la1 >= 0 && la1 <= i) ||
                              (la2 >= 0 && la2 <= i));
            if (i == rst_at) begin
                e = '{tag, 4'b1111, 8'hFF, 1'b0, 1'b0};
            end else begin
                e = expect_slot(tag, disp_hex, disp_dp, disp_lz,
                                i, p, (i == 15));
            end
            sb.push_back(e);
            load     = (i == la1) || (i == la2);
            hex_in   = (i == la2) ? h2 : h1;
            dp_in    = dp;
            blank_lz = lz;
            reset    = (i == rst_at);
            tick();
            load  = 1'b0;
            reset = 1'b0;
            check();
            if (i == rst_at) begin
                disp_hex = 16'h0000;
                disp_dp  = 4'h0;
                disp_lz  = 1'b0;
                return;
            end
        end
        if (la2 >= 0) disp_hex = h2;
        else if (la1 >= 0) disp_hex = h1;
        if (la1 >= 0) begin
            disp_dp = dp;
            disp_lz = lz;
        end
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        hex_in   = 16'h0000;
        dp_in    = 4'h0;
        blank_lz = 1'b0;

        for (int i = 0; i < 3; i++) begin
            sb.push_back('{"reset", 4'b1111, 8'hFF, 1'b0, 1'b0});
            tick();
            check();
        end

        run_frame("scan0", -1, 16'h0, -1, 16'h0, 4'h0, 1'b0, -1);
        run_frame("scan1", -1, 16'h0, -1, 16'h0, 4'h0, 1'b0, -1);

        run_frame("ld12AF", 5, 16'h12AF, -1, 16'h0, 4'b0100, 1'b0, -1);
        run_frame("show12AF", -1, 16'h0, -1, 16'h0, 4'h0, 1'b0, -1);

        run_frame("ldlz50", 2, 16'h0050, -1, 16'h0, 4'h0, 1'b1, -1);
        run_frame("lz50", -1, 16'h0, -1, 16'h0, 4'h0, 1'b0, -1);

        run_frame("ldlz0", 7, 16'h0000, -1, 16'h0, 4'h0, 1'b1, -1);
        run_frame("lz0", -1, 16'h0, -1, 16'h0, 4'h0, 1'b0, -1);

        run_frame("dbl", 3, 16'h1111, 9, 16'h2222, 4'h0, 1'b0, -1);
        run_frame("show2222", -1, 16'h0, -1, 16'h0, 4'h0, 1'b0, -1);

        run_frame("ldwrap", 15, 16'h3333, -1, 16'h0, 4'h0, 1'b0, -1);
        run_frame("show3333", -1, 16'h0, -1, 16'h0, 4'h0, 1'b0, -1);

        run_frame("rstpend", 4, 16'hABCD, -1, 16'h0, 4'hF, 1'b0, 10);
        run_frame("post_rst0", -1, 16'h0, -1, 16'h0, 4'h0, 1'b0, -1);
        run_frame("post_rst1", -1, 16'h0, -1, 16'h0, 4'h0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Time-multiplexing controller for a 4-digit common-anode seven-segment display. It sits between the period-counter result logic and the board pins. It owns the single hex-to-segment decoder instance and sequences it across the four digits with a refresh prescaler. New display values are double-buffered and committed only at frame boundaries, so a digit never shows a mix of old and new data.

## Interface
- `N`, default 16: prescaler width; one digit slot lasts 2^N clocks, one frame lasts 4·2^N clocks.
- `clk`, in, 1: system clock; all logic rises on this edge.
- `reset`, in, 1: synchronous, active-high reset.
- `load`, in, 1: one-cycle strobe that captures `hex_in`, `dp_in` and `blank_lz`.
- `hex_in`, in, 16: four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `dp_in`, in, 4: decimal-point enables, active-high; bit k belongs to digit k.
- `blank_lz`, in, 1: leading-zero blanking enable, captured with `load`.
- `an`, out, 4: anode enables, active-low; bit k drives digit k.
- `sseg`, out, 8: segments, active-low; [7]=dp, [6:0]={a,b,c,d,e,f,g}.
- `pending`, out, 1: a loaded value is waiting for the next frame boundary.
- `frame_done`, out, 1: one-cycle pulse on each frame wrap.

## Operation
- Prescaler `q` (N bits) increments every clock and wraps from 2^N−1 to 0. `tick` = (`q` == 2^N−1).
- Digit index `idx` (2 bits) advances on `tick`: 0→1→2→3→0. `wrap` = `tick` && `idx`==3.
- Shadow register (`sh_hex`, `sh_dp`, `sh_lz`) is written when `load`=1, and `pending` is then set.
  - `load` while `pending`=1 overwrites the shadow; the last load wins.
- Active register (`a_hex`, `a_dp`, `a_lz`) is written only on `wrap`:
  - `wrap` && `pending`: active ← shadow, and `pending` clears.
  - `wrap` && `load` in the same cycle: active ← `hex_in`/`dp_in`/`blank_lz` directly, and `pending` = 0.
  - `wrap` with no pending data: the active register holds its value.
- `frame_done` = registered `wrap`.
- Digit select: `nib` = `a_hex`[4·idx+3 : 4·idx] feeds the decoder hex input. The decoder dp input is ~`a_dp`[idx].
- Blanking, applied only when `a_lz`=1:
  - Digit k (k=3,2,1) is blanked if every nibble from k up to 3 is zero.
  - Digit 0 is never blanked.
  - A blanked slot drives `an`=4'b1111 and `sseg`=8'hFF.
- Non-blanked slot: `an` = ~(4'b0001 << `idx`), and `sseg` = decoder output.
- `an` and `sseg` are registered: they reflect the `idx` and active register of the previous cycle.
- Reset values:
  - `q`=0, `idx`=0, active and shadow registers all 0, `pending`=0, `frame_done`=0.
  - `an`=4'b1111, `sseg`=8'hFF.
- Reset asserted mid-frame or mid-pending: all state returns to the reset values on that edge, and the pending data is discarded.

## Timing
- `load` to `pending`=1: one cycle.
- `load` to visible data: at the next `wrap`, then one more cycle for the output register. Worst case is 4·2^N+1 clocks.
- `an`/`sseg` change exactly one cycle after `idx` changes. No cycle ever has two anodes low.
- First cycle after reset release: `an`=4'b1110 and `sseg`=8'b10000001 (digit 0, value 0, dp off).
- `frame_done` is high for exactly one cycle every 4·2^N clocks. It is first asserted 4·2^N clocks after reset release.
- No other handshake exists. `load` is always accepted and there is no back-pressure.

## Test plan
- **Reset and scan** (N=2), no load: `an` reads 1111, then 1110 ×4 cycles, 1101 ×4, 1011 ×4, 0111 ×4, then repeats. `sseg`=8'h81 throughout unblanked slots. `frame_done` pulses every 16 cycles.
- **Load 16'h12AF, dp_in=4'b0100, blank_lz=0**, mid-frame:
  - `pending` goes high the next cycle.
  - Display is unchanged until the wrap.
  - Next frame: digit0 `sseg`=8'hB8, digit1 =8'h88, digit2 =8'h12 (dp on), digit3 =8'hCF.
  - `pending` clears at the wrap.
- **Leading-zero blanking**, `hex_in`=16'h0050, `blank_lz`=1:
  - Slots 3 and 2 show `an`=1111 and `sseg`=FF.
  - Slot 1 shows `sseg`=8'hA4; slot 0 shows `sseg`=8'h81.
  - `hex_in`=0: only digit 0 is lit, showing "0".
- **Double load before wrap**: load 16'h1111, then load 16'h2222. The next frame shows 2222 only, and 1111 never appears.
- **Load coincident with wrap**: `load` asserted with 16'h3333 on the `wrap` cycle. The frame starting next shows 3333, and `pending` stays 0.
- **Reset mid-pending**: load, then assert `reset` before the wrap. Outputs return to 1111/FF, `pending`=0, and the display resumes showing 0000.
